// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divider-chain blocks: the period-checker FSM
// state encoding, the error-counter width and a saturating error-counter
// update helper.
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_LOCK  = 2'd2
    } div_state_e;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    // Clear has priority over increment; increment saturates at all-ones.
    function automatic logic [ERR_CNT_W-1:0] err_cnt_next(
        input logic [ERR_CNT_W-1:0] cnt,
        input logic                 clr,
        input logic                 inc
    );
        logic [ERR_CNT_W-1:0] nxt;
        nxt = cnt;
        if (clr) begin
            nxt = '0;
        end else if (inc && (cnt != ERR_CNT_MAX)) begin
            nxt = cnt + ERR_CNT_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/div_period_checker_if.sv
// -----------------------------------------------------------------------------
// div_period_checker_if
// Signal bundle between the divider-chain environment and div_period_checker.
//   DIV_IN      env -> checker  divided waveform, synchronous to CLK
//   CLR_ERR     env -> checker  synchronous clear of ERR_CNT
//   LOCKED      checker -> env  waveform matched for LOCK_CNT periods
//   ERR         checker -> env  one-cycle error pulse
//   ERR_CNT     checker -> env  saturating error count
//   PERIOD_VLD  checker -> env  one-cycle "new period measured" pulse
//   HIGH_LEN    checker -> env  last measured high-phase length
//   LOW_LEN     checker -> env  last measured low-phase length
//   STATE       checker -> env  current FSM state (debug observation)
//
// Handshake: there is no back-pressure. PERIOD_VLD and ERR are single-cycle
// valid strobes; the consumer must take HIGH_LEN/LOW_LEN in the cycle
// PERIOD_VLD is high. The lengths then hold until the next PERIOD_VLD.
// -----------------------------------------------------------------------------
interface div_period_checker_if
    import div_pkg::*;
#(
    parameter int CNT_W = 8
) ();

    logic                 DIV_IN;
    logic                 CLR_ERR;
    logic                 LOCKED;
    logic                 ERR;
    logic [ERR_CNT_W-1:0] ERR_CNT;
    logic                 PERIOD_VLD;
    logic [CNT_W-1:0]     HIGH_LEN;
    logic [CNT_W-1:0]     LOW_LEN;
    div_state_e           STATE;

    modport master (
        output DIV_IN,
        output CLR_ERR,
        input  LOCKED,
        input  ERR,
        input  ERR_CNT,
        input  PERIOD_VLD,
        input  HIGH_LEN,
        input  LOW_LEN,
        input  STATE
    );

    modport slave (
        input  DIV_IN,
        input  CLR_ERR,
        output LOCKED,
        output ERR,
        output ERR_CNT,
        output PERIOD_VLD,
        output HIGH_LEN,
        output LOW_LEN,
        output STATE
    );

endinterface

// File: rtl/edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
// Registers a 1-bit input once and flags rising/falling transitions
// combinationally in the cycle the new level is present.
//   CLK     in   clock, rising edge
//   RST_N   in   asynchronous active-low reset
//   din_i   in   sampled level
//   rise_o  out  din_i & ~d_q (after the first post-reset cycle)
//   fall_o  out  ~din_i & d_q
// -----------------------------------------------------------------------------
module edge_det (
    input  logic CLK,
    input  logic RST_N,
    input  logic din_i,
    output logic rise_o,
    output logic fall_o
);

    logic d_q;
    // Reset forces d_q low even if the input is high. Without this qualifier a
    // high input at reset release would look like a rise and the partial
    // phase behind it would be measured; primed_q hides that first cycle.
    logic primed_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d_q      <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            d_q      <= din_i;
            primed_q <= 1'b1;
        end
    end

    assign rise_o = primed_q & din_i & ~d_q;
    assign fall_o = ~din_i & d_q;

endmodule

// File: rtl/div_period_checker.sv
// -----------------------------------------------------------------------------
// div_period_checker
// Measures high/low phase lengths of a divided waveform, flags phases that
// differ from EXP_HIGH/EXP_LOW, times out on a stuck input and reports lock
// after LOCK_CNT consecutive good periods.
//   CLK    in   clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   bus    slave modport of div_period_checker_if (see that file)
// All outputs are registered: every response appears one CLK after the cycle
// in which the DIV_IN transition is first seen.
// -----------------------------------------------------------------------------
module div_period_checker
    import div_pkg::*;
#(
    parameter int EXP_HIGH = 4,
    parameter int EXP_LOW  = 4,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    div_period_checker_if.slave bus
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  EXP_HIGH_C = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0]  EXP_LOW_C  = CNT_W'(EXP_LOW);
    localparam logic [GOOD_W-1:0] LOCK_C     = GOOD_W'(LOCK_CNT);

    logic rise;
    logic fall;

    edge_det u_edge_det (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .din_i  (bus.DIV_IN),
        .rise_o (rise),
        .fall_o (fall)
    );

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GOOD_W-1:0]    good_q, good_d;
    logic                 bad_q, bad_d;       // current period already failed
    logic [CNT_W-1:0]     hi_cap_q;           // high length awaiting the rise
    logic                 locked_q;
    logic                 err_q;
    logic                 pvld_q;
    logic [CNT_W-1:0]     high_len_q;
    logic [CNT_W-1:0]     low_len_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic tracking;
    logic hi_bad;
    logic lo_bad;
    logic timeout;
    logic err_d;

    // Phase counter: 1 in the first cycle after an edge, saturating.
    always_comb begin
        cnt_d = cnt_q;
        if (rise || fall) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // cnt_q still holds the just-finished phase length in the edge cycle.
    assign tracking = (state_q != ST_IDLE);
    assign hi_bad   = tracking && fall && (cnt_q != EXP_HIGH_C);
    assign lo_bad   = tracking && rise && (cnt_q != EXP_LOW_C);
    assign timeout  = tracking && !rise && !fall && (cnt_q == CNT_MAX);
    assign err_d    = hi_bad | lo_bad | timeout;

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        unique case (state_q)
            ST_IDLE: begin
                // Anything before the first rise is a partial phase.
                if (rise) begin
                    state_d = ST_ARMED;
                    good_d  = '0;
                    bad_d   = 1'b0;
                end
            end
            default: begin
                if (timeout) begin
                    state_d = ST_IDLE;
                    good_d  = '0;
                    bad_d   = 1'b0;
                end else if (hi_bad) begin
                    state_d = ST_ARMED;
                    good_d  = '0;
                    bad_d   = 1'b1;
                end else if (rise) begin
                    bad_d = 1'b0;
                    if (lo_bad) begin
                        state_d = ST_ARMED;
                        good_d  = '0;
                    end else if (bad_q) begin
                        good_d = '0;
                    end else begin
                        if (good_q != LOCK_C) begin
                            good_d = good_q + GOOD_W'(1);
                        end
                        if (good_d == LOCK_C) begin
                            state_d = ST_LOCK;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            good_q     <= '0;
            bad_q      <= 1'b0;
            hi_cap_q   <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            pvld_q     <= 1'b0;
            high_len_q <= '0;
            low_len_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            locked_q  <= (state_d == ST_LOCK);
            err_q     <= err_d;
            pvld_q    <= tracking && rise;
            err_cnt_q <= err_cnt_next(err_cnt_q, bus.CLR_ERR, err_d);
            if (tracking && fall) begin
                hi_cap_q <= cnt_q;
            end
            // Both lengths publish together so a reader never sees a mixed pair.
            if (tracking && rise) begin
                high_len_q <= hi_cap_q;
                low_len_q  <= cnt_q;
            end
        end
    end

    assign bus.LOCKED     = locked_q;
    assign bus.ERR        = err_q;
    assign bus.ERR_CNT    = err_cnt_q;
    assign bus.PERIOD_VLD = pvld_q;
    assign bus.HIGH_LEN   = high_len_q;
    assign bus.LOW_LEN    = low_len_q;
    assign bus.STATE      = state_q;

endmodule

// File: tb/tb_div_period_checker.sv
// -----------------------------------------------------------------------------
// tb_div_period_checker
// Drives DIV_IN as a sequence of phases (level, length). A phase-level model
// predicts each ERR / PERIOD_VLD event and pushes it into exp_q; a monitor on
// the falling clock edge pops and compares whenever the DUT shows an event,
// and checks LOCKED / ERR_CNT stay put between events.
// -----------------------------------------------------------------------------
module tb_div_period_checker;
    import div_pkg::*;

    localparam int EXP_H  = 4;
    localparam int EXP_L  = 4;
    localparam int LOCK_N = 4;
    localparam int CW     = 8;

    typedef struct packed {
        logic [31:0] cyc;
        logic        pvld;
        logic        err;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        locked;
        logic [7:0]  ecnt;
    } exp_t;

    exp_t exp_q[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    div_period_checker_if #(.CNT_W(CW)) bus ();

    div_period_checker #(
        .EXP_HIGH (EXP_H),
        .EXP_LOW  (EXP_L),
        .LOCK_CNT (LOCK_N),
        .CNT_W    (CW)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model state ----------------
    bit m_track;     // a fresh rise has been seen, periods are being judged
    bit m_locked;
    bit m_bad;       // high phase of the current period was wrong
    int m_good;
    int m_hi_meas;
    int m_hi_out;
    int m_lo_out;
    int m_ecnt;
    bit cur_level;
    int cur_len;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_track = 0; m_locked = 0; m_bad = 0; m_good = 0;
        m_hi_meas = 0; m_hi_out = 0; m_lo_out = 0; m_ecnt = 0;
    endtask

    task automatic push_rec(input int ecyc, input bit pvld, input bit err, input bit clr);
        exp_t r;
        if (clr) m_ecnt = 0;
        else if (err && m_ecnt < 255) m_ecnt++;
        r.cyc    = 32'(ecyc);
        r.pvld   = pvld;
        r.err    = err;
        r.hi     = 8'(m_hi_out);
        r.lo     = 8'(m_lo_out);
        r.locked = m_locked;
        r.ecnt   = 8'(m_ecnt);
        exp_q.push_back(r);
    endtask

    // A transition to lvl ends a phase of length plen; its effect shows at ecyc.
    task automatic model_edge(input bit lvl, input int plen, input int ecyc, input bit clr);
        int cap;
        bit lo_bad;
        cap = (plen > 255) ? 255 : plen;
        if (!m_track) begin
            if (lvl) begin
                m_track = 1; m_good = 0; m_bad = 0;
            end
        end else if (!lvl) begin
            m_hi_meas = cap;
            if (cap != EXP_H) begin
                m_bad = 1; m_good = 0; m_locked = 0;
                push_rec(ecyc, 1'b0, 1'b1, clr);
            end
        end else begin
            lo_bad   = (cap != EXP_L);
            m_hi_out = m_hi_meas;
            m_lo_out = cap;
            if (lo_bad || m_bad) begin
                m_good = 0;
                if (lo_bad) m_locked = 0;
            end else begin
                if (m_good < LOCK_N) m_good++;
                if (m_good == LOCK_N) m_locked = 1;
            end
            m_bad = 0;
            push_rec(ecyc, 1'b1, lo_bad, clr);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; holds lvl for len rising edges.
    task automatic drive_phase(input bit lvl, input int len, input bit clr);
        int k;
        k = cyc;
        bus.DIV_IN  = lvl;
        bus.CLR_ERR = clr;
        if (lvl != cur_level) model_edge(lvl, cur_len, k + 1, clr);
        if (m_track && len >= 256) begin
            m_track = 0; m_locked = 0; m_good = 0; m_bad = 0;
            push_rec(k + 256, 1'b0, 1'b1, 1'b0);
        end
        repeat (len) begin
            @(posedge clk);
            #1;
            bus.CLR_ERR = 1'b0;
        end
        cur_len   = (lvl == cur_level) ? cur_len + len : len;
        cur_level = lvl;
    endtask

    task automatic good_periods(input int n);
        repeat (n) begin
            drive_phase(1'b1, EXP_H, 1'b0);
            drive_phase(1'b0, EXP_L, 1'b0);
        end
    endtask

    function automatic int rand_len();
        if ($urandom_range(0, 3) != 0) return 4;
        return int'($urandom_range(1, 7));
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_locked"},   int'(bus.LOCKED), 0);
        check({tag, "_err"},      int'(bus.ERR), 0);
        check({tag, "_pvld"},     int'(bus.PERIOD_VLD), 0);
        check({tag, "_err_cnt"},  int'(bus.ERR_CNT), 0);
        check({tag, "_high_len"}, int'(bus.HIGH_LEN), 0);
        check({tag, "_low_len"},  int'(bus.LOW_LEN), 0);
        check({tag, "_state"},    int'(bus.STATE), int'(ST_IDLE));
    endtask

    // ---------------- scoreboard monitor ----------------
    bit last_locked = 0;
    int last_ecnt   = 0;

    always @(negedge clk) begin
        exp_t r;
        if (!rst_n) begin
            last_locked = 0;
            last_ecnt   = 0;
        end else if (bus.ERR || bus.PERIOD_VLD) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: ERR=%0b PERIOD_VLD=%0b at cycle %0d, expected no event",
                         bus.ERR, bus.PERIOD_VLD, cyc);
            end else begin
                r = exp_q.pop_front();
                check("event_cycle", cyc, int'(r.cyc));
                check("period_vld",  int'(bus.PERIOD_VLD), int'(r.pvld));
                check("err",         int'(bus.ERR), int'(r.err));
                check("high_len",    int'(bus.HIGH_LEN), int'(r.hi));
                check("low_len",     int'(bus.LOW_LEN), int'(r.lo));
                check("locked",      int'(bus.LOCKED), int'(r.locked));
                check("err_cnt",     int'(bus.ERR_CNT), int'(r.ecnt));
                last_locked = r.locked;
                last_ecnt   = int'(r.ecnt);
            end
        end else begin
            check("locked_stable",  int'(bus.LOCKED), int'(last_locked));
            check("err_cnt_stable", int'(bus.ERR_CNT), last_ecnt);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.DIV_IN  = 1'b0;
        bus.CLR_ERR = 1'b0;
        cur_level   = 1'b0;
        cur_len     = 0;
        model_reset();
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ideal 4/4 waveform from reset: lock after the 5th rise.
        drive_phase(1'b0, 3, 1'b0);
        good_periods(6);

        // One long high phase while locked, then relock.
        drive_phase(1'b1, 5, 1'b0);
        drive_phase(1'b0, EXP_L, 1'b0);
        good_periods(5);

        // Randomised phase lengths, biased towards the nominal value.
        repeat (40) begin
            drive_phase(1'b1, rand_len(), 1'b0);
            drive_phase(1'b0, rand_len(), 1'b0);
        end

        // Relock, then a stuck-high input: one timeout error, back to idle.
        good_periods(6);
        drive_phase(1'b1, 300, 1'b0);
        check("timeout_state", int'(bus.STATE), int'(ST_IDLE));
        drive_phase(1'b0, EXP_L, 1'b0);
        good_periods(6);

        // Reset for one cycle in the middle of a high phase while locked.
        drive_phase(1'b1, 2, 1'b0);
        check("pre_reset_locked", int'(bus.LOCKED), 1);
        check("pre_reset_queue", exp_q.size(), 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs_zero("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        drive_phase(1'b0, EXP_L, 1'b0);
        good_periods(6);

        // Saturate ERR_CNT, then clear it in the same cycle as an error.
        repeat (160) begin
            drive_phase(1'b1, 1, 1'b0);
            drive_phase(1'b0, 1, 1'b0);
        end
        check("err_cnt_saturated", int'(bus.ERR_CNT), 255);
        drive_phase(1'b1, 1, 1'b1);
        check("err_cnt_cleared", int'(bus.ERR_CNT), 0);
        drive_phase(1'b0, EXP_L, 1'b0);
        good_periods(6);

        repeat (4) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_period_checker.md
DIV_PERIOD_CHECKER -- requirements
Module: div_period_checker

Interface
REQ-001 Parameter EXP_HIGH, default 4: expected high-phase length of DIV_IN, in CLK cycles.
REQ-002 Parameter EXP_LOW, default 4: expected low-phase length of DIV_IN, in CLK cycles.
REQ-003 Parameter LOCK_CNT, default 4: consecutive good periods required to assert LOCKED.
REQ-004 Parameter CNT_W, default 8: width of the phase counter and of the length outputs.
REQ-005 CLK  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low.
REQ-007 DIV_IN  input  1  divided waveform from the upstream divide-by-8 stage, synchronous to CLK.
REQ-008 CLR_ERR  input  1  synchronous clear of ERR_CNT.
REQ-009 LOCKED  output  1  DIV_IN has matched EXP_HIGH/EXP_LOW for LOCK_CNT consecutive periods.
REQ-010 ERR  output  1  one-cycle pulse on any phase-length mismatch or timeout.
REQ-011 ERR_CNT  output  8  saturating error count.
REQ-012 PERIOD_VLD  output  1  one-cycle pulse when a full period has been measured.
REQ-013 HIGH_LEN  output  CNT_W  last measured high-phase length.
REQ-014 LOW_LEN  output  CNT_W  last measured low-phase length.

Function
REQ-015 DIV_IN SHALL be registered once into d_q; rise = DIV_IN & ~d_q, fall = ~DIV_IN & d_q, both evaluated combinationally in the same cycle.
REQ-016 The phase counter SHALL load 1 on any edge cycle and otherwise increment, saturating at 2^CNT_W-1.
REQ-017 On a fall, the counter value SHALL be captured as the high length; on a rise, it SHALL be captured as the low length. A 4-cycle high phase therefore captures 4.
REQ-018 The FSM SHALL have states IDLE, ARMED and LOCK.
REQ-019 IDLE: the counter and any partial phase are ignored. The first rise SHALL move the FSM to ARMED, with no capture and no check.
REQ-020 ARMED/LOCK, on a fall: if the captured high length differs from EXP_HIGH, the block SHALL pulse ERR, mark the current period bad and clear the good-period count.
REQ-021 ARMED/LOCK, on a rise: the block SHALL update LOW_LEN and HIGH_LEN together and pulse PERIOD_VLD. If the low length differs from EXP_LOW, it SHALL pulse ERR and mark the period bad.
REQ-022 At each rise, a period with no mismatch SHALL increment the good-period count, saturating at LOCK_CNT. A bad period SHALL clear the count to 0.
REQ-023 ARMED SHALL move to LOCK at the rise where the good-period count reaches LOCK_CNT.
REQ-024 LOCK SHALL move to ARMED on any mismatch. LOCKED SHALL be deasserted in the same cycle as the ERR pulse.
REQ-025 Timeout: in ARMED or LOCK, if the counter saturates with no edge, the block SHALL pulse ERR once, clear the good-period count, and move to IDLE.
REQ-026 All outputs SHALL be registered. Every event response (ERR, PERIOD_VLD, LEN update, LOCKED change) SHALL be visible exactly 1 CLK after the cycle in which DIV_IN changed.
REQ-027 ERR_CNT SHALL increment on every ERR pulse and saturate at 255.
REQ-028 If CLR_ERR and ERR occur in the same cycle, CLR_ERR SHALL win and ERR_CNT SHALL become 0.
REQ-029 Multiple error causes in one cycle SHALL produce a single ERR pulse and a single ERR_CNT increment.
REQ-030 LOCKED SHALL equal (state == LOCK).

Reset
REQ-031 On RST_N low, the block SHALL immediately force: state IDLE; d_q, counter and good-period count to 0; LOCKED, ERR and PERIOD_VLD to 0; ERR_CNT, HIGH_LEN and LOW_LEN to 0.
REQ-032 After reset is released mid-waveform, the block SHALL discard the partial phase and wait for a fresh rise; no ERR SHALL be produced for that partial phase.

Structure
REQ-033 The FSM state encoding and the ERR_CNT width (8) SHALL live in a shared package, div_pkg, reused by the other divider-chain blocks.
REQ-034 Edge detection (d_q register plus rise/fall) SHALL be a single sub-module, edge_det, with a 1-bit input and rise/fall outputs. All other logic SHALL stay flat.

Verification
REQ-035 Ideal 4/4 DIV_IN from reset -> PERIOD_VLD begins at the 2nd rise with HIGH_LEN=4 and LOW_LEN=4; LOCKED=1 one cycle after the 5th rise; ERR never asserted.
REQ-036 While locked, one high phase of 5 cycles -> ERR and LOCKED=0 one cycle after that fall; ERR_CNT=1; relock one cycle after the 4th subsequent good rise.
REQ-037 DIV_IN held at 1 for 300 cycles while ARMED -> exactly one ERR when the counter reaches 255; state IDLE; no further ERR.
REQ-038 Force 300 errors, then assert CLR_ERR in the same cycle as an ERR -> ERR_CNT reads 255 before the clear and 0 after it.
REQ-039 Assert RST_N low for 1 cycle mid-high-phase while locked -> all outputs 0 immediately; no ERR from the partial phase; LOCKED returns one cycle after the 5th rise following release.
